// File: rtl/pc_stack_pkg.sv
// pc_stack_pkg: stack operation encoding and push/pop decode for the return-address stack.
package pc_stack_pkg;
  typedef enum logic [1:0] {OP_NOP, OP_PUSH, OP_POP, OP_REPLACE} stack_op_t;
  function automatic stack_op_t decode_op(input logic push, input logic pop);
    return push ? (pop ? OP_REPLACE : OP_PUSH) : (pop ? OP_POP : OP_NOP);
  endfunction
endpackage

// File: rtl/pc_stack_if.sv
// pc_stack_if: control and status bundle between the CPU controller and the return-address stack.
interface pc_stack_if #(parameter int WIDTH = 12, parameter int DEPTH = 8);
  localparam int CW = $clog2(DEPTH + 1);
  logic             push;
  logic             pop;
  logic             flush;
  logic             err_clr;
  logic [WIDTH-1:0] push_data;
  logic [WIDTH-1:0] top;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;
  modport master(output push, pop, flush, err_clr, push_data,
                 input top, count, empty, full, overflow, underflow);
  modport slave(input push, pop, flush, err_clr, push_data,
                output top, count, empty, full, overflow, underflow);
endinterface

// File: rtl/pc_stack_mem.sv
// pc_stack_mem: DEPTH x WIDTH register array, one synchronous write port, one asynchronous read port.
module pc_stack_mem #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/pc_stack.sv
// pc_stack: return-address stack with push/pop/replace, flush, occupancy and sticky error flags.
// Define PC_STACK_WRAP_EN to make a push into a full stack overwrite the oldest entry.
module pc_stack
  import pc_stack_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input logic       clk,
  input logic       rst,
  pc_stack_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
`ifdef PC_STACK_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  logic [PW-1:0]    ptr, ptr_n, waddr;
  logic [CW-1:0]    cnt, cnt_n;
  logic             ovf, unf, ovf_set, unf_set, we, empty, full;
  logic [WIDTH-1:0] rdata;
  stack_op_t        op;
  assign empty = cnt == '0;
  assign full  = cnt == FULL_CNT;
  always_comb begin
    op      = decode_op(bus.push, bus.pop);
    we      = 1'b0;
    waddr   = ptr;
    ptr_n   = ptr;
    cnt_n   = cnt;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case (op)
      OP_PUSH: begin
        we      = !full || WRAP;
        ptr_n   = we ? ptr + 1'b1 : ptr;
        cnt_n   = full ? cnt : cnt + 1'b1;
        ovf_set = full;
      end
      OP_POP: begin
        ptr_n   = empty ? ptr : ptr - 1'b1;
        cnt_n   = empty ? cnt : cnt - 1'b1;
        unf_set = empty;
      end
      // replace on an empty stack degrades to a push after flagging underflow
      OP_REPLACE: begin
        we      = 1'b1;
        waddr   = empty ? ptr : ptr - 1'b1;
        ptr_n   = empty ? ptr + 1'b1 : ptr;
        cnt_n   = empty ? cnt + 1'b1 : cnt;
        unf_set = empty;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ptr <= bus.flush ? '0 : ptr_n;
      cnt <= bus.flush ? '0 : cnt_n;
      ovf <= (ovf & ~bus.err_clr) | (ovf_set & ~bus.flush);
      unf <= (unf & ~bus.err_clr) | (unf_set & ~bus.flush);
    end
  pc_stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk  (clk),
    .we   (we & ~bus.flush & ~rst),
    .waddr(waddr),
    .wdata(bus.push_data),
    .raddr(ptr - 1'b1),
    .rdata(rdata)
  );
  assign bus.top       = empty ? '0 : rdata;
  assign bus.count     = cnt;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.overflow  = ovf;
  assign bus.underflow = unf;
endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed checks of pc_stack with WIDTH=12, DEPTH=4 (honours PC_STACK_WRAP_EN).
module tb_pc_stack;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  pc_stack_if #(.WIDTH(12), .DEPTH(4)) bus();
  pc_stack #(.WIDTH(12), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic pu, input logic po, input logic [11:0] d);
    bus.push = pu;
    bus.pop = po;
    bus.push_data = d;
    step();
    bus.push = 1'b0;
    bus.pop = 1'b0;
  endtask
  task automatic clr();
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
  endtask
  logic [11:0] exp_pops [4];
  initial begin
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.flush = 1'b0;
    bus.err_clr = 1'b0;
    bus.push_data = '0;
    step();
    rst = 1'b0;
    check("rst_count", 32'(bus.count), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_top", 32'(bus.top), 0);
    check("rst_ovf", 32'(bus.overflow), 0);
    check("rst_unf", 32'(bus.underflow), 0);
    op(1, 0, 12'h101);
    op(1, 0, 12'h102);
    op(1, 0, 12'h103);
    check("push3_top", 32'(bus.top), 32'h103);
    check("push3_count", 32'(bus.count), 3);
    check("push3_empty", 32'(bus.empty), 0);
    check("push3_full", 32'(bus.full), 0);
    op(0, 1, 0);
    check("pop1_top", 32'(bus.top), 32'h102);
    op(0, 1, 0);
    check("pop2_top", 32'(bus.top), 32'h101);
    op(0, 1, 0);
    check("pop3_top", 32'(bus.top), 0);
    check("pop3_empty", 32'(bus.empty), 1);
    check("pop3_ovf", 32'(bus.overflow), 0);
    check("pop3_unf", 32'(bus.underflow), 0);
    for (int i = 0; i < 4; i++) op(1, 0, 12'(12'hA1 + i));
    check("fill_full", 32'(bus.full), 1);
    check("fill_ovf", 32'(bus.overflow), 0);
    op(1, 0, 12'hA5);
    check("ovf_flag", 32'(bus.overflow), 1);
    check("ovf_count", 32'(bus.count), 4);
`ifdef PC_STACK_WRAP_EN
    exp_pops = '{12'hA5, 12'hA4, 12'hA3, 12'hA2};
`else
    exp_pops = '{12'hA4, 12'hA3, 12'hA2, 12'hA1};
`endif
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_pop%0d", i), 32'(bus.top), 32'(exp_pops[i]));
      op(0, 1, 0);
    end
    check("ovf_drain_empty", 32'(bus.empty), 1);
    check("ovf_held", 32'(bus.overflow), 1);
    clr();
    check("ovf_clr", 32'(bus.overflow), 0);
    op(0, 1, 0);
    check("unf_flag", 32'(bus.underflow), 1);
    check("unf_count", 32'(bus.count), 0);
    bus.err_clr = 1'b1;
    op(0, 1, 0);
    bus.err_clr = 1'b0;
    check("unf_clr_race", 32'(bus.underflow), 1);
    clr();
    check("unf_clr", 32'(bus.underflow), 0);
    op(1, 0, 12'h010);
    op(1, 0, 12'h020);
    op(1, 1, 12'h030);
    check("repl_top", 32'(bus.top), 32'h030);
    check("repl_count", 32'(bus.count), 2);
    check("repl_ovf", 32'(bus.overflow), 0);
    check("repl_unf", 32'(bus.underflow), 0);
    op(0, 1, 0);
    check("repl_pop_top", 32'(bus.top), 32'h010);
    op(0, 1, 0);
    op(1, 1, 12'h0BE);
    check("repl_empty_unf", 32'(bus.underflow), 1);
    check("repl_empty_count", 32'(bus.count), 1);
    check("repl_empty_top", 32'(bus.top), 32'h0BE);
    op(1, 0, 12'h111);
    op(1, 0, 12'h222);
    check("pre_flush_count", 32'(bus.count), 3);
    bus.flush = 1'b1;
    op(1, 0, 12'h333);
    bus.flush = 1'b0;
    check("flush_count", 32'(bus.count), 0);
    check("flush_top", 32'(bus.top), 0);
    check("flush_empty", 32'(bus.empty), 1);
    check("flush_unf_kept", 32'(bus.underflow), 1);
    check("flush_ovf_kept", 32'(bus.overflow), 0);
    op(1, 0, 12'h0FF);
    op(1, 0, 12'h0FF);
    check("pre_rst_count", 32'(bus.count), 2);
    rst = 1'b1;
    op(1, 0, 12'h0FF);
    rst = 1'b0;
    check("mid_rst_count", 32'(bus.count), 0);
    check("mid_rst_empty", 32'(bus.empty), 1);
    check("mid_rst_top", 32'(bus.top), 0);
    check("mid_rst_unf", 32'(bus.underflow), 0);
    check("mid_rst_ovf", 32'(bus.overflow), 0);
    op(1, 0, 12'h055);
    check("post_rst_top", 32'(bus.top), 32'h055);
    check("post_rst_count", 32'(bus.count), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised hardware return-address stack for the pipelined CPU, next generation of the push/pop path the controller drives during call/return instructions. It holds up to DEPTH program-counter values of WIDTH bits and presents the current top combinationally from registered storage, so the fetch stage can select it as a PC source. It adds a simultaneous push+pop (replace) operation, a pipeline flush, occupancy reporting and sticky overflow/underflow error flags.

## Interface
- WIDTH, 12, bit width of each stored PC value (>=1)
- DEPTH, 8, number of entries; power of two, >=2
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- push  in  1  push push_data this cycle
- pop  in  1  pop top entry this cycle
- flush  in  1  discard all entries (pipeline kill of speculative calls)
- push_data  in  WIDTH  value to push
- err_clr  in  1  clear sticky error flags
- top  out  WIDTH  current top entry; 0 when empty
- count  out  $clog2(DEPTH+1)  number of valid entries
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- overflow  out  1  sticky: a push was issued while full (without pop)
- underflow  out  1  sticky: a pop was issued while empty

## Operation
- Priority per cycle: rst > flush > push/pop decode.
- rst: count=0, stack pointer=0, overflow=0, underflow=0; storage contents not cleared (top forced 0 by empty).
- flush: count=0, pointer=0; push/pop ignored that cycle; error flags untouched.
- Decode {push,pop}: 00 NOP; 10 PUSH; 01 POP; 11 REPLACE.
- PUSH, not full: mem[ptr]=push_data, ptr+1, count+1.
- PUSH, full: overflow<=1; behaviour per PC_STACK_WRAP_EN.
- POP, not empty: ptr-1, count-1. POP, empty: no state change, underflow<=1.
- REPLACE, not empty: mem[ptr-1]=push_data; ptr, count unchanged; never sets overflow.
- REPLACE, empty: underflow<=1, then performed as PUSH (count becomes 1).
- Pointer arithmetic modulo DEPTH ($clog2(DEPTH) bits); count saturates at DEPTH, never wraps.
- err_clr clears both flags; a new error in the same cycle wins (flag reads 1 next cycle).

## Timing
- All state updates on rising clk; no combinational path from push/pop/push_data to any output.
- top, count, empty, full reflect the operation of edge N from just after edge N (one-cycle visibility, zero extra latency).
- top = mem[ptr-1] when count>0, else 0.
- Flags set at the edge of the offending operation, visible next cycle, held until err_clr or rst.

## Configuration
- PC_STACK_WRAP_EN defined: PUSH when full overwrites the oldest entry (circular); ptr advances, count stays DEPTH, top = new value; overflow still set.
- Undefined: PUSH when full is dropped; storage, ptr, count, top unchanged; overflow set.

## Structure
- Package pc_stack_pkg: typedef enum logic [1:0] stack_op_t {OP_NOP, OP_PUSH, OP_POP, OP_REPLACE}; helper function decode_op(push,pop).
- One sub-module pc_stack_mem: DEPTH x WIDTH register array, single synchronous write port, one asynchronous read port; no reset on contents.
- Top level holds pointer, count, flags and the op decode.

## Test plan
- WIDTH=12, DEPTH=4; rst, push 0x101,0x102,0x103 -> top=0x103, count=3, empty=0, full=0; three pops -> top=0, empty=1, no flags.
- Fill with 0xA1..0xA4, push 0xA5 -> overflow=1; with WRAP_EN top=0xA5, count=4, then 4 pops yield 0xA5,0xA4,0xA3,0xA2; without, top=0xA4 and pops yield 0xA4..0xA1.
- Empty stack, pop -> underflow=1, count=0; next cycle err_clr with another pop -> underflow stays 1; err_clr alone -> underflow=0.
- Push 0x010,0x020; push+pop with 0x030 -> top=0x030, count=2, no flags; pop -> top=0x010.
- Push 0x111 and 0x222, then flush asserted with push=1 -> count=0, top=0, push ignored; prior flags unchanged.
- Push 0x0FF twice, assert rst mid-sequence together with push -> count=0, empty=1, flags=0, top=0 next cycle.
